// File: rtl/accessory_pkg.sv
// Shared types and constants for the G-15 accessory responder.
package accessory_pkg;

    localparam int WORD_BITS_DEFAULT = 29;
    localparam int OUT_DEPTH_DEFAULT = 2;

    typedef enum logic {
        IN_IDLE  = 1'b0,
        IN_ARMED = 1'b1
    } in_state_t;

    // Width of a counter that indexes n positions (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/accessory_if.sv
// Host-side word handshakes: words to the computer (in_*) and from it (out_*).
interface accessory_if
    import accessory_pkg::*;
#(
    parameter int WORD_BITS = WORD_BITS_DEFAULT
);

    logic [WORD_BITS-1:0] in_word;
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_BITS-1:0] out_word;
    logic                 out_valid;
    logic                 out_ready;

    // Host bridge side.
    modport master (
        output in_word, in_valid, out_ready,
        input  in_ready, out_word, out_valid
    );

    // Responder side.
    modport slave (
        input  in_word, in_valid, out_ready,
        output in_ready, out_word, out_valid
    );

endinterface

// File: rtl/accessory_fifo.sv
// Small synchronous FIFO for words received from the computer.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module accessory_fifo
    import accessory_pkg::*;
#(
    parameter int WIDTH = WORD_BITS_DEFAULT,
    parameter int DEPTH = OUT_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int            AW      = cnt_width(DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    // The head reads as zero while empty, which keeps out_word clean after reset.
    assign pop_data = empty ? '0 : mem_q[rd_q[AW-1:0]];

    // Storage write.
    // NOTE: the word array is deliberately not reset; only the pointers are, and they decide what is visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

    // Read and write pointers.
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_ONE;
            if (do_pop)  rd_q <= rd_q + PTR_ONE;
        end
    end

endmodule

// File: rtl/accessory_responder.sv
// Device end of the G-15 accessory interface: serialises host words onto PL19
// (LSB first) on start/stop-input commands, and assembles PL20 bits into words.
module accessory_responder
    import accessory_pkg::*;
#(
    parameter int WORD_BITS = WORD_BITS_DEFAULT,
    parameter int OUT_DEPTH = OUT_DEPTH_DEFAULT
) (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       PL19_START_INPUT,
    input  logic       PL19_STOP_INPUT,
    input  logic       PL19_SHIFT_CMD_M20,
    output logic       PL19_INPUT,
    input  logic       PL20_SHIFT,
    input  logic       PL20_OUTPUT,
    accessory_if.slave host,
    output logic       underrun,
    output logic       overrun,
    output logic       in_active
);

    localparam int            CW       = cnt_width(WORD_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_BITS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    in_state_t            state_q, state_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic [WORD_BITS-1:0] hold_q, hold_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 loaded_q, loaded_d;
    logic                 hold_full_q, hold_full_d;
    logic                 underrun_q, underrun_d;
    logic                 pl19_q, pl19_d;
    logic                 armed_shift, entering, wrap, idle_load;

    logic [WORD_BITS-1:0] asm_q, asm_d;
    logic [CW-1:0]        ocnt_q, ocnt_d;
    logic                 overrun_q, overrun_d;
    logic                 push, pop;
    logic                 fifo_full, fifo_empty;
    logic [WORD_BITS-1:0] fifo_head;

    // Input FSM state register.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) state_q <= IN_IDLE;
        else     state_q <= state_d;
    end

    // Input FSM next state: STOP wins over START from any state.
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (PL19_STOP_INPUT)       state_d = IN_IDLE;
        else if (PL19_START_INPUT) state_d = IN_ARMED;
    end

    // Input FSM outputs.
    always_comb begin
        in_active = (state_q == IN_ARMED);
    end

    // Serialiser: holding register, shift register, bit counter and word loads.
    always_comb begin
        shift_d     = shift_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        loaded_d    = loaded_q;
        hold_full_d = hold_full_q;
        underrun_d  = underrun_q;

        armed_shift = (state_q == IN_ARMED) && PL19_SHIFT_CMD_M20;
        entering    = (state_q == IN_IDLE) && (state_d == IN_ARMED);
        wrap        = armed_shift && (cnt_q == LAST_BIT);
        // Armed with nothing loaded and sitting on a word boundary: take a word as soon as one arrives.
        idle_load   = (state_q == IN_ARMED) && !loaded_q && (cnt_q == '0) && hold_full_q;

        if (state_d == IN_IDLE) begin
            // Leaving or staying idle drops any partial word; the holding word survives.
            shift_d  = '0;
            cnt_d    = '0;
            loaded_d = 1'b0;
        end else begin
            if (armed_shift) begin
                shift_d = shift_q >> 1;
                cnt_d   = wrap ? '0 : cnt_q + CNT_ONE;
                if (!loaded_q) underrun_d = 1'b1;
            end
            if (entering || wrap || idle_load) begin
                cnt_d    = '0;
                loaded_d = hold_full_q;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                end
            end
        end

        // A load only happens from a full slot and a write only into an empty one, so they never collide.
        if (host.in_valid && !hold_full_q) begin
            hold_d      = host.in_word;
            hold_full_d = 1'b1;
        end

        pl19_d = (state_d == IN_ARMED) && loaded_d && shift_d[0];
    end

    // Serialiser registers.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            shift_q     <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            loaded_q    <= 1'b0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
            pl19_q      <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            loaded_q    <= loaded_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
            pl19_q      <= pl19_d;
        end
    end

    // Assembler: PL20 bits enter at the MSB end; a low PL20_SHIFT discards any partial word.
    always_comb begin
        asm_d     = asm_q;
        ocnt_d    = ocnt_q;
        overrun_d = overrun_q;
        push      = 1'b0;
        pop       = !fifo_empty && host.out_ready;
        if (PL20_SHIFT) begin
            asm_d = {PL20_OUTPUT, asm_q[WORD_BITS-1:1]};
            if (ocnt_q == LAST_BIT) begin
                ocnt_d = '0;
                push   = 1'b1;
                if (fifo_full && !pop) overrun_d = 1'b1;
            end else begin
                ocnt_d = ocnt_q + CNT_ONE;
            end
        end else begin
            ocnt_d = '0;
        end
    end

    // Assembler registers.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            asm_q     <= '0;
            ocnt_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            asm_q     <= asm_d;
            ocnt_q    <= ocnt_d;
            overrun_q <= overrun_d;
        end
    end

    accessory_fifo #(
        .WIDTH (WORD_BITS),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (CLOCK),
        .rst       (rst),
        .push      (push),
        .push_data (asm_d),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign PL19_INPUT     = pl19_q;
    assign host.in_ready  = !hold_full_q;
    assign host.out_valid = !fifo_empty;
    assign host.out_word  = fifo_head;
    assign underrun       = underrun_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_accessory_responder.sv
// Directed bench for accessory_responder with hand-computed expected words.
module tb_accessory_responder;

    localparam int W = 29;

    logic CLOCK = 1'b0;
    logic rst;
    logic start_input, stop_input, shift_cmd;
    logic pl19_input;
    logic pl20_shift, pl20_output;
    logic underrun, overrun, in_active;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] got;

    accessory_if #(.WORD_BITS(W)) bus ();

    accessory_responder #(.WORD_BITS(W), .OUT_DEPTH(2)) dut (
        .CLOCK              (CLOCK),
        .rst                (rst),
        .PL19_START_INPUT   (start_input),
        .PL19_STOP_INPUT    (stop_input),
        .PL19_SHIFT_CMD_M20 (shift_cmd),
        .PL19_INPUT         (pl19_input),
        .PL20_SHIFT         (pl20_shift),
        .PL20_OUTPUT        (pl20_output),
        .host               (bus.slave),
        .underrun           (underrun),
        .overrun            (overrun),
        .in_active          (in_active)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
        else             n_pass++;
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from it.
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic host_write(input logic [W-1:0] w);
        bus.in_word  = w;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start_input = 1'b1;
        tick();
        start_input = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_input = 1'b1;
        tick();
        stop_input = 1'b0;
    endtask

    // Sample the visible PL19 bit, then consume it; n bits collected LSB first.
    task automatic shift_bits(input int n, output logic [W-1:0] bits);
        bits = '0;
        for (int i = 0; i < n; i++) begin
            bits[i]   = pl19_input;
            shift_cmd = 1'b1;
            tick();
        end
        shift_cmd = 1'b0;
    endtask

    // Drive bits lo..hi-1 of w on PL20; PL20_SHIFT is left high.
    task automatic send_bits(input logic [W-1:0] w, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            pl20_shift  = 1'b1;
            pl20_output = w[i];
            tick();
        end
    endtask

    task automatic send_word(input logic [W-1:0] w);
        send_bits(w, 0, W);
        pl20_shift = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start_input = 1'b0; stop_input = 1'b0; shift_cmd = 1'b0;
        pl20_shift = 1'b0; pl20_output = 1'b0;
        bus.in_word = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #12 rst = 1'b0;
        tick();

        // Reset state
        check("rst_pl19",      32'(pl19_input),    32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_word",  32'(bus.out_word),  32'd0);
        check("rst_underrun",  32'(underrun),      32'd0);
        check("rst_overrun",   32'(overrun),       32'd0);
        check("rst_in_active", 32'(in_active),     32'd0);

        // Two queued words sent back to back
        host_write(29'h0000_0005);
        check("a_hold_full_ready", 32'(bus.in_ready), 32'd0);
        pulse_start();
        check("a_in_active",  32'(in_active),    32'd1);
        check("a_ready_load", 32'(bus.in_ready), 32'd1);
        check("a_first_bit",  32'(pl19_input),   32'd1);
        host_write(29'h1ABC_DEF0);
        shift_bits(W, got);
        check("a_word0", 32'(got), 32'h0000_0005);
        shift_bits(W, got);
        check("a_word1", 32'(got), 32'h1ABC_DEF0);
        check("a_underrun", 32'(underrun),     32'd0);
        check("a_ready_end", 32'(bus.in_ready), 32'd1);
        pulse_stop();

        // Armed with no word: underrun, then a mid-stream word waits for the boundary
        pulse_start();
        shift_bits(3, got);
        check("b_empty_bits", 32'(got),      32'd0);
        check("b_underrun",   32'(underrun), 32'd1);
        host_write(29'h0ABC_1234);
        shift_bits(26, got);
        check("b_rest_zero", 32'(got), 32'd0);
        shift_bits(W, got);
        check("b_word", 32'(got), 32'h0ABC_1234);
        pulse_stop();

        // STOP mid-word keeps the holding word; restart sends it from bit 0
        host_write(29'h1234_5678);
        pulse_start();
        host_write(29'h0F0F_0F0F);
        shift_bits(10, got);
        check("c_partial", 32'(got), 32'h0000_0278);
        pulse_stop();
        check("c_stop_active", 32'(in_active),    32'd0);
        check("c_stop_pl19",   32'(pl19_input),   32'd0);
        check("c_hold_kept",   32'(bus.in_ready), 32'd0);
        pulse_start();
        check("c_restart_ready", 32'(bus.in_ready), 32'd1);
        shift_bits(W, got);
        check("c_restart_word", 32'(got), 32'h0F0F_0F0F);
        pulse_stop();
        start_input = 1'b1;
        stop_input  = 1'b1;
        tick();
        start_input = 1'b0;
        stop_input  = 1'b0;
        check("c_start_stop", 32'(in_active), 32'd0);

        // Output assembly, partial discard, FIFO full and overrun
        send_bits(29'h0555_5555, 0, W - 1);
        check("d_not_yet", 32'(bus.out_valid), 32'd0);
        send_bits(29'h0555_5555, W - 1, W);
        pl20_shift = 1'b0;
        check("d_valid", 32'(bus.out_valid), 32'd1);
        check("d_word",  32'(bus.out_word),  32'h0555_5555);
        send_bits(29'h1FFF_FFFF, 0, 5);
        pl20_shift = 1'b0;
        tick();
        send_word(29'h0333_3333);
        check("e_no_overrun", 32'(overrun), 32'd0);
        send_word(29'h1000_0001);
        check("e_overrun", 32'(overrun),      32'd1);
        check("e_head",    32'(bus.out_word), 32'h0555_5555);
        bus.out_ready = 1'b1;
        tick();
        check("e_second", 32'(bus.out_word), 32'h0333_3333);
        tick();
        check("e_drained", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Asynchronous reset in the middle of traffic in both directions
        send_word(29'h0333_3333);
        host_write(29'h1FFF_FFFF);
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            shift_cmd   = 1'b1;
            pl20_shift  = 1'b1;
            pl20_output = 1'b1;
            tick();
        end
        check("f_pre_pl19", 32'(pl19_input), 32'd1);
        #3 rst = 1'b1;
        #1;
        shift_cmd = 1'b0; pl20_shift = 1'b0; pl20_output = 1'b0;
        check("f_pl19",      32'(pl19_input),    32'd0);
        check("f_in_ready",  32'(bus.in_ready),  32'd1);
        check("f_out_valid", 32'(bus.out_valid), 32'd0);
        check("f_out_word",  32'(bus.out_word),  32'd0);
        check("f_underrun",  32'(underrun),      32'd0);
        check("f_overrun",   32'(overrun),       32'd0);
        check("f_in_active", 32'(in_active),     32'd0);
        @(posedge CLOCK);
        #1 rst = 1'b0;
        host_write(29'h0246_8ACE);
        pulse_start();
        shift_bits(W, got);
        check("f_fresh_word",     32'(got),      32'h0246_8ACE);
        check("f_fresh_underrun", 32'(underrun), 32'd0);
        pulse_stop();

        // Push and pop in the same cycle on a full FIFO
        send_word(29'h0555_5555);
        send_word(29'h0333_3333);
        send_bits(29'h1000_0001, 0, W - 1);
        bus.out_ready = 1'b1;
        send_bits(29'h1000_0001, W - 1, W);
        pl20_shift    = 1'b0;
        bus.out_ready = 1'b0;
        check("g_no_overrun", 32'(overrun),      32'd0);
        check("g_head",       32'(bus.out_word), 32'h0333_3333);
        bus.out_ready = 1'b1;
        tick();
        check("g_third", 32'(bus.out_word), 32'h1000_0001);
        tick();
        check("g_drained", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
